// File: rtl/ysyx_22050710_ifu_fb.sv
// Buffered instruction fetch unit: owns the fetch PC, issues one aligned read per
// instruction over a valid/ready memory channel and queues the results in a small
// fetch buffer that drains to decode. A redirect flushes the buffer and drops any
// in-flight response.
// Optional: define YSYX_22050710_IFU_TRACE_EN for a simulation-only push/redirect trace.
module ysyx_22050710_ifu_fb #(
    parameter int unsigned           INST_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           FB_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(64'h8000_0000)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_resp_valid,
    output logic                  o_mem_resp_ready,
    input  logic [DATA_WIDTH-1:0] i_mem_resp_data,
    input  logic                  i_mem_resp_err,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic                  o_fault
);

    localparam int unsigned NumLanes = DATA_WIDTH / INST_WIDTH;
    localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
    localparam int unsigned LaneLsb  = $clog2(INST_WIDTH / 8);
    localparam int unsigned BeatLsb  = $clog2(DATA_WIDTH / 8);
    localparam int unsigned PtrW     = $clog2(FB_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;

    localparam logic [ADDR_WIDTH-1:0] AlignMask = {ADDR_WIDTH{1'b1}} << BeatLsb;
    localparam logic [ADDR_WIDTH-1:0] InstMask  = ~({ADDR_WIDTH{1'b1}} << LaneLsb);
    localparam logic [ADDR_WIDTH-1:0] Step      = ADDR_WIDTH'(INST_WIDTH / 8);
    localparam logic [CntW-1:0]       Depth     = CntW'(FB_DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fpc_q, fpc_d;
    logic [ADDR_WIDTH-1:0]   req_pc_q, req_pc_d;  // address held stable while REQ is pending
    logic                    discard_q, discard_d;
    logic                    stop_q, stop_d;      // fetch halted after a fault entry

    logic [ADDR_WIDTH-1:0]   pc_mem_q    [FB_DEPTH];
    logic [INST_WIDTH-1:0]   inst_mem_q  [FB_DEPTH];
    logic                    fault_mem_q [FB_DEPTH];
    logic [PtrW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]         count_q;

    logic                    push, pop, push_fault, credit, misaligned;
    logic [INST_WIDTH-1:0]   push_inst, lane_inst;
    logic [LaneW-1:0]        lane;
    logic [NumLanes-1:0][INST_WIDTH-1:0] beat_lanes;

    assign beat_lanes = i_mem_resp_data;
    if (NumLanes > 1) begin : g_lane
        assign lane = LaneW'(fpc_q >> LaneLsb);
    end else begin : g_lane_single
        assign lane = '0;
    end
    assign lane_inst  = beat_lanes[lane];

    // The only outstanding transaction lives in REQ/WAIT, so in IDLE credit is just free space.
    assign credit     = count_q < Depth;
    assign misaligned = |(fpc_q & InstMask);
    assign pop        = (count_q != '0) && i_inst_ready && !i_redirect;

    // Fetch FSM next state, PC update and push request
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        stop_d     = stop_q;
        push       = 1'b0;
        push_inst  = '0;
        push_fault = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!stop_q && credit) begin
                    if (misaligned) begin
                        push       = 1'b1;
                        push_fault = 1'b1;
                        stop_d     = 1'b1;
                    end else begin
                        state_d  = StReq;
                        req_pc_d = fpc_q;
                    end
                end
            end
            StReq: begin
                if (i_mem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (i_mem_resp_valid) begin
                    state_d = StIdle;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        push       = 1'b1;
                        push_inst  = lane_inst;
                        push_fault = i_mem_resp_err;
                        fpc_d      = fpc_q + Step;
                        if (i_mem_resp_err) stop_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (i_redirect) begin
            fpc_d  = i_redirect_pc;
            stop_d = 1'b0;
            push   = 1'b0;
            if (state_q == StIdle) begin
                state_d = StIdle;
            end else if (state_q == StWait && i_mem_resp_valid) begin
                // The outstanding response retires this very cycle; nothing left to drop.
                discard_d = 1'b0;
            end else begin
                discard_d = 1'b1;
            end
        end
    end

    // FSM and fetch PC registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            fpc_q     <= RESET_PC;
            req_pc_q  <= RESET_PC;
            discard_q <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
            stop_q    <= stop_d;
        end
    end

    // Fetch buffer pointers and occupancy; redirect empties it
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Fetch buffer storage; contents are don't-care while the entry is invalid
    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fpc_q;
            inst_mem_q[wr_ptr_q]  <= push_inst;
            fault_mem_q[wr_ptr_q] <= push_fault;
        end
    end

    assign o_mem_req_valid  = (state_q == StReq);
    assign o_mem_req_addr   = ((state_q == StIdle) ? fpc_q : req_pc_q) & AlignMask;
    assign o_mem_resp_ready = 1'b1;
    assign o_inst_valid     = (count_q != '0);
    assign o_pc             = o_inst_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign o_inst           = o_inst_valid ? inst_mem_q[rd_ptr_q]  : '0;
    assign o_fault          = o_inst_valid ? fault_mem_q[rd_ptr_q] : 1'b0;

`ifdef YSYX_22050710_IFU_TRACE_EN
    // Simulation-only trace of pushes and redirects
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (i_redirect) $display("ifu: redirect %x", i_redirect_pc);
            else if (push)  $display("ifu: pc=%x inst=%x fault=%b", fpc_q, push_inst, push_fault);
        end
    end
`else
`endif

endmodule

// File: tb/tb_ysyx_22050710_ifu_fb.sv
// Directed self-checking bench for the buffered fetch unit.
module tb_ysyx_22050710_ifu_fb;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;

    int checks = 0;
    int errors = 0;

    ysyx_22050710_ifu_fb dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_mem_req_valid  (req_valid),
        .i_mem_req_ready  (req_ready),
        .o_mem_req_addr   (req_addr),
        .i_mem_resp_valid (resp_valid),
        .o_mem_resp_ready (resp_ready),
        .i_mem_resp_data  (resp_data),
        .i_mem_resp_err   (resp_err),
        .o_inst_valid     (inst_valid),
        .i_inst_ready     (inst_ready),
        .o_pc             (pc),
        .o_inst           (inst),
        .o_fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory side: wait for a request, accept it, return one beat the next cycle.
    task automatic serve(input logic [63:0] beat, input logic berr,
                         output logic got, output logic [63:0] addr);
        got  = 1'b0;
        addr = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (req_valid) begin
                got  = 1'b1;
                addr = req_addr;
            end else begin
                tick();
            end
        end
        if (got) begin
            req_ready  = 1'b1;
            tick();
            req_ready  = 1'b0;
            resp_valid = 1'b1;
            resp_data  = beat;
            resp_err   = berr;
            tick();
            resp_valid = 1'b0;
            resp_err   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (pc !== 64'h0 || inst !== 32'h0 || fault !== 1'b0) begin
            errors++; $display("FAIL reset_head: got pc=%h inst=%h fault=%b want 0/0/0", pc, inst, fault);
        end
        checks++; if (req_addr !== 64'h8000_0000) begin errors++; $display("FAIL reset_addr: got %h want 80000000", req_addr); end
        checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL resp_ready: got %b want 1", resp_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0000) begin
            errors++; $display("FAIL first_req: got valid=%b addr=%h want 1/80000000", req_valid, req_addr);
        end
    endtask

    task automatic test_lane_select();
        logic got;
        logic [63:0] a;
        serve(64'h1111_2222_3333_4444, 1'b0, got, a);
        checks++; if (!got || a !== 64'h8000_0000) begin errors++; $display("FAIL lane_req0: got %b/%h want 1/80000000", got, a); end
        checks++; if (inst_valid !== 1'b1 || pc !== 64'h8000_0000 || inst !== 32'h3333_4444 || fault !== 1'b0) begin
            errors++; $display("FAIL lane0_head: got v=%b pc=%h inst=%h f=%b want 1/80000000/33334444/0", inst_valid, pc, inst, fault);
        end
        serve(64'h1111_2222_3333_4444, 1'b0, got, a);
        checks++; if (!got || a !== 64'h8000_0000) begin errors++; $display("FAIL lane_req1: got %b/%h want 1/80000000", got, a); end
        checks++; if (pc !== 64'h8000_0000) begin errors++; $display("FAIL lane_head_held: got %h want 80000000", pc); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (inst_valid !== 1'b1 || pc !== 64'h8000_0004 || inst !== 32'h1111_2222) begin
            errors++; $display("FAIL lane1_head: got v=%b pc=%h inst=%h want 1/80000004/11112222", inst_valid, pc, inst);
        end
    endtask

    task automatic test_redirect_wait();
        checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0008) begin
            errors++; $display("FAIL rd_pre_req: got valid=%b addr=%h want 1/80000008", req_valid, req_addr);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rd_pre_valid: got %b want 1", inst_valid); end
        redirect    = 1'b1;
        redirect_pc = 64'h8000_1000;
        tick();
        redirect = 1'b0;
        checks++; if (inst_valid !== 1'b0 || pc !== 64'h0) begin
            errors++; $display("FAIL rd_flush: got v=%b pc=%h want 0/0", inst_valid, pc);
        end
        resp_valid = 1'b1;
        resp_data  = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_dropped: got %b want 0", inst_valid); end
        tick();
        checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_1000) begin
            errors++; $display("FAIL rd_new_req: got valid=%b addr=%h want 1/80001000", req_valid, req_addr);
        end
    endtask

    task automatic test_full();
        logic got;
        logic seen;
        logic [63:0] a;
        logic [63:0] exp_pc [4];
        logic [31:0] exp_in [4];
        exp_pc = '{64'h8000_1004, 64'h8000_1008, 64'h8000_100C, 64'h8000_1010};
        exp_in = '{32'h2000_0001, 32'h1000_0002, 32'h2000_0003, 32'h1000_0004};
        for (int k = 0; k < 4; k++) begin
            serve({32'h2000_0000 + 32'(k), 32'h1000_0000 + 32'(k)}, 1'b0, got, a);
            checks++; if (!got) begin errors++; $display("FAIL full_fill%0d: got no request want request", k); end
        end
        seen = 1'b0;
        repeat (10) begin tick(); if (req_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL full_no_req: got req_valid=1 want 0"); end
        checks++; if (pc !== 64'h8000_1000 || inst !== 32'h1000_0000) begin
            errors++; $display("FAIL full_head: got pc=%h inst=%h want 80001000/10000000", pc, inst);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        serve(64'h2000_0004_1000_0004, 1'b0, got, a);
        checks++; if (!got || a !== 64'h8000_1010) begin errors++; $display("FAIL full_refill: got %b/%h want 1/80001010", got, a); end
        seen = 1'b0;
        repeat (10) begin tick(); if (req_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL full_one_req: got extra req want none"); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (inst_valid !== 1'b1 || pc !== exp_pc[i] || inst !== exp_in[i]) begin
                errors++; $display("FAIL full_drain%0d: got v=%b pc=%h inst=%h want 1/%h/%h", i, inst_valid, pc, inst, exp_pc[i], exp_in[i]);
            end
            inst_ready = 1'b1;
            tick();
            inst_ready = 1'b0;
        end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", inst_valid); end
    endtask

    task automatic test_fault();
        logic got;
        logic seen;
        logic [63:0] a;
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0010;
        tick();
        redirect = 1'b0;
        checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_1010) begin
            errors++; $display("FAIL req_stable: got valid=%b addr=%h want 1/80001010", req_valid, req_addr);
        end
        serve(64'h0123_4567_89AB_CDEF, 1'b0, got, a);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL req_drop: got %b want 0", inst_valid); end
        serve(64'h5555_6666_7777_8888, 1'b1, got, a);
        checks++; if (!got || a !== 64'h8000_0010) begin errors++; $display("FAIL err_req: got %b/%h want 1/80000010", got, a); end
        checks++; if (inst_valid !== 1'b1 || fault !== 1'b1 || pc !== 64'h8000_0010 || inst !== 32'h7777_8888) begin
            errors++; $display("FAIL err_head: got v=%b f=%b pc=%h inst=%h want 1/1/80000010/77778888", inst_valid, fault, pc, inst);
        end
        seen = 1'b0;
        repeat (10) begin tick(); if (req_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL err_stop: got req_valid=1 want 0"); end
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0002;
        tick();
        redirect = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mis_flush: got %b want 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1 || fault !== 1'b1 || pc !== 64'h8000_0002 || inst !== 32'h0) begin
            errors++; $display("FAIL mis_head: got v=%b f=%b pc=%h inst=%h want 1/1/80000002/0", inst_valid, fault, pc, inst);
        end
        seen = 1'b0;
        repeat (10) begin tick(); if (req_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mis_no_req: got req_valid=1 want 0"); end
    endtask

    task automatic test_reset_mid();
        logic got;
        logic [63:0] a;
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0020;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0020) begin
            errors++; $display("FAIL rm_req: got valid=%b addr=%h want 1/80000020", req_valid, req_addr);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0 || req_addr !== 64'h8000_0000) begin
            errors++; $display("FAIL rm_reset: got rv=%b iv=%b addr=%h want 0/0/80000000", req_valid, inst_valid, req_addr);
        end
        rst_n      = 1'b1;
        resp_valid = 1'b1;
        resp_data  = 64'hEEEE_EEEE_FFFF_FFFF;
        tick();
        resp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h8000_0000) begin
            errors++; $display("FAIL rm_stray: got iv=%b rv=%b addr=%h want 0/1/80000000", inst_valid, req_valid, req_addr);
        end
        serve(64'h9999_AAAA_BBBB_CCCC, 1'b0, got, a);
        checks++; if (inst_valid !== 1'b1 || pc !== 64'h8000_0000 || inst !== 32'hBBBB_CCCC || fault !== 1'b0) begin
            errors++; $display("FAIL rm_head: got v=%b pc=%h inst=%h f=%b want 1/80000000/bbbbcccc/0", inst_valid, pc, inst, fault);
        end
        tick();
        checks++; if (req_valid !== 1'b1 || req_addr !== 64'h8000_0000) begin
            errors++; $display("FAIL back_to_back: got valid=%b addr=%h want 1/80000000", req_valid, req_addr);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        resp_err    = 1'b0;
        inst_ready  = 1'b0;
        test_reset();
        test_lane_select();
        test_redirect_wait();
        test_full();
        test_fault();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_ifu_fb.md
# ysyx_22050710_ifu_fb

Buffered, handshaked instruction fetch unit, the successor to the single-shot IFU. It owns the fetch PC, issues one aligned read per instruction over a valid/ready memory request/response channel, and extracts the addressed instruction from the returned data beat. Fetched instructions go into a FB_DEPTH-entry fetch buffer that drains to decode over a valid/ready handshake. A redirect from EXU/WBU flushes the buffer and discards any in-flight response.

## Interface
- INST_WIDTH, 32: instruction width in bits; power of two, ≤ DATA_WIDTH.
- DATA_WIDTH, 64: memory data beat width; power-of-two multiple of INST_WIDTH.
- ADDR_WIDTH, 64: PC/address width.
- FB_DEPTH, 4: fetch buffer entries; power of two, ≥ 2.
- RESET_PC, 64'h8000_0000: fetch PC after reset.

- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_redirect  in  1  flush and restart fetch at i_redirect_pc
- i_redirect_pc  in  ADDR_WIDTH  new fetch PC
- o_mem_req_valid  out  1  read request valid
- i_mem_req_ready  in  1  memory accepts request
- o_mem_req_addr  out  ADDR_WIDTH  fetch PC with low log2(DATA_WIDTH/8) bits zeroed
- i_mem_resp_valid  in  1  read data valid
- o_mem_resp_ready  out  1  tied 1
- i_mem_resp_data  in  DATA_WIDTH  read beat
- i_mem_resp_err  in  1  access fault for this response
- o_inst_valid  out  1  buffer non-empty
- i_inst_ready  in  1  decode consumes head
- o_pc  out  ADDR_WIDTH  head entry PC
- o_inst  out  INST_WIDTH  head entry instruction
- o_fault  out  1  head entry carries an access/misalignment fault

## Operation
- Lane select: lane = fpc[log2(DATA_WIDTH/8)-1 : log2(INST_WIDTH/8)]; inst = i_mem_resp_data[lane*INST_WIDTH +: INST_WIDTH].
- FSM states: IDLE, REQ, WAIT.
  - IDLE→REQ when credit available: entries + inflight < FB_DEPTH.
  - REQ: o_mem_req_valid=1; on i_mem_req_ready → WAIT. Valid, once raised, holds with stable address until accepted, redirect notwithstanding.
  - WAIT: on i_mem_resp_valid push {fpc, inst, i_mem_resp_err}, fpc += INST_WIDTH/8, → IDLE.
- Misaligned fpc (low log2(INST_WIDTH/8) bits ≠ 0) in IDLE: push {fpc, 0, fault=1} without a memory access; fetch stops (stays IDLE) until redirect.
- After pushing any fault entry (err or misaligned), no further fetch until redirect.
- Redirect (highest priority): buffer emptied, fpc ← i_redirect_pc, fault stop cleared. In REQ or WAIT a discard flag is set; the matching response is accepted and dropped, fpc unchanged by it. Same-cycle push/pop ignored.
- Pop when o_inst_valid && i_inst_ready; push and pop in same cycle allowed at full or empty.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset (i_rst_n=0 at edge): fpc=RESET_PC, FSM=IDLE, buffer empty, discard=0. Outputs: o_mem_req_valid=0, o_inst_valid=0, o_pc=0, o_inst=0, o_fault=0, o_mem_req_addr=RESET_PC aligned. Reset mid-transaction abandons it; the first response after reset is ignored only if it arrives while FSM is IDLE/REQ.
- First o_mem_req_valid: cycle after reset release.
- Response accepted in cycle N → o_inst_valid by cycle N+1.
- Zero-wait memory (ready=1, response cycle after acceptance): one instruction per 3 cycles (REQ, WAIT, IDLE).
- Redirect in cycle N → o_inst_valid=0 in N+1; new request at earliest N+1 (IDLE) or after outstanding transaction retires.
- o_pc/o_inst/o_fault are registered buffer outputs; 0 when empty.

## Configuration
- YSYX_22050710_IFU_TRACE_EN defined: every push prints "ifu: pc=%x inst=%x fault=%b" via $display; every redirect prints "ifu: redirect %x". Not synthesised.
- Undefined: no simulation output; logic identical.

## Test plan
- Reset held 3 cycles, release → all outputs at reset values; o_mem_req_addr=0x80000000, req_valid rises next cycle.
- Beat 0x11112222_33334444 for 0x80000000, same beat for 0x80000004 → decode sees pc 0x80000000 inst 0x33334444, then pc 0x80000004 inst 0x11112222.
- i_inst_ready=0, zero-wait memory → exactly 4 entries fetched, o_mem_req_valid stays 0; single pop → exactly one new request.
- Redirect to 0x80001000 while in WAIT for 0x80000008 → that response dropped, buffer empty, next o_mem_req_addr=0x80001000.
- i_mem_resp_err=1 at 0x80000010 → entry with o_fault=1, no further requests until redirect; redirect to 0x80000002 → fault entry pc 0x80000002, no memory request.
- i_rst_n low during WAIT → state reset, stray response ignored, fetch restarts at 0x80000000.
